// File: rtl/c5_mem_arbiter_pkg.sv
// c5 memory arbiter shared types and constants.
// Owner encoding, address width, default starvation bound.
package c5_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int C5_WADDR_W    = 30;
  localparam int C5_STARVE_DEF = 4;
  localparam int C5_CNT_W      = 4;

  localparam logic [C5_CNT_W-1:0] C5_CNT_MAX = 4'hF;

endpackage

// File: rtl/c5_mem_arbiter_if.sv
// Bus bundle between c5_cpu, the DMA master and the RAM.
// master: arbiter view; slave: environment (cpu/dma/ram) view.
interface c5_mem_arbiter_if;
  import c5_pkg::*;

  logic [C5_WADDR_W-1:0] I_cpu_address_next;
  logic [3:0]            I_cpu_byte_we_next;
  logic [31:0]           I_cpu_data_w;
  logic [31:0]           O_cpu_data_r;
  logic                  O_cpu_pause;

  logic                  I_dma_req;
  logic [C5_WADDR_W-1:0] I_dma_addr;
  logic [3:0]            I_dma_we;
  logic [31:0]           I_dma_wdata;
  logic                  O_dma_ack;
  logic                  O_dma_rvalid;
  logic [31:0]           O_dma_rdata;

  logic [C5_WADDR_W-1:0] O_ram_addr;
  logic [3:0]            O_ram_we;
  logic [31:0]           O_ram_wdata;
  logic [31:0]           I_ram_rdata;
  logic                  I_ram_wait;

  modport master (
    input  I_cpu_address_next,
    input  I_cpu_byte_we_next,
    input  I_cpu_data_w,
    output O_cpu_data_r,
    output O_cpu_pause,
    input  I_dma_req,
    input  I_dma_addr,
    input  I_dma_we,
    input  I_dma_wdata,
    output O_dma_ack,
    output O_dma_rvalid,
    output O_dma_rdata,
    output O_ram_addr,
    output O_ram_we,
    output O_ram_wdata,
    input  I_ram_rdata,
    input  I_ram_wait
  );

  modport slave (
    output I_cpu_address_next,
    output I_cpu_byte_we_next,
    output I_cpu_data_w,
    input  O_cpu_data_r,
    input  O_cpu_pause,
    output I_dma_req,
    output I_dma_addr,
    output I_dma_we,
    output I_dma_wdata,
    input  O_dma_ack,
    input  O_dma_rvalid,
    input  O_dma_rdata,
    input  O_ram_addr,
    input  O_ram_we,
    input  O_ram_wdata,
    output I_ram_rdata,
    output I_ram_wait
  );

endinterface

// File: rtl/c5_arb_wait_cnt.sv
// Saturating DMA wait counter; clear beats hold beats increment.
// Ports: I_clk, I_rst, I_clr, I_hold, I_inc -> O_due (cnt >= STARVE_MAX).
module c5_arb_wait_cnt
  import c5_pkg::*;
#(
  parameter int STARVE_MAX = C5_STARVE_DEF
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_clr,
  input  logic I_hold,
  input  logic I_inc,
  output logic O_due
);

  localparam logic [C5_CNT_W:0] LIM = (C5_CNT_W + 1)'(STARVE_MAX);

  logic [C5_CNT_W-1:0] cnt;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt <= '0;
    end else if (I_clr) begin
      cnt <= '0;
    end else if (I_inc && !I_hold && cnt != C5_CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt + 1 > LIM is cnt >= LIM, and stays a live compare for LIM == 0
  assign O_due = ({1'b0, cnt} + 1'b1) > LIM;

endmodule

// File: rtl/c5_mem_arbiter.sv
// Shares the single-port SoC RAM between c5_cpu and a DMA master.
// Ports: I_clk, I_rst, bus (cpu / dma / ram signals, master view).
module c5_mem_arbiter
  import c5_pkg::*;
#(
  parameter int STARVE_MAX = C5_STARVE_DEF
) (
  input logic            I_clk,
  input logic            I_rst,
  c5_mem_arbiter_if.master bus
);

  owner_e owner;
  owner_e rd_owner;
  logic   due;
  logic   ack;
  logic   rd_dma_read;

  always_comb begin
    owner = OWN_CPU;
    if (bus.I_dma_req && due) owner = OWN_DMA;
  end

  always_comb begin
    bus.O_ram_addr  = bus.I_cpu_address_next;
    bus.O_ram_we    = bus.I_cpu_byte_we_next;
    bus.O_ram_wdata = bus.I_cpu_data_w;
    if (owner == OWN_DMA) begin
      bus.O_ram_addr  = bus.I_dma_addr;
      bus.O_ram_we    = bus.I_dma_we;
      bus.O_ram_wdata = bus.I_dma_wdata;
    end
  end

  assign ack             = (owner == OWN_DMA) & ~bus.I_ram_wait;
  assign bus.O_dma_ack   = ack;
  assign bus.O_cpu_pause = (owner == OWN_DMA) | bus.I_ram_wait;

  c5_arb_wait_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_wait_cnt (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_clr (ack | ~bus.I_dma_req),
    .I_hold(bus.I_ram_wait),
    .I_inc (bus.I_dma_req),
    .O_due (due)
  );

  // A stalled slot is not accepted, so the owner of the
  // pending read only moves on accepted cycles.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rd_owner    <= OWN_CPU;
      rd_dma_read <= 1'b0;
    end else begin
      rd_dma_read <= ack & ~|bus.I_dma_we;
      if (!bus.I_ram_wait) rd_owner <= owner;
    end
  end

  assign bus.O_dma_rvalid = rd_dma_read & (rd_owner == OWN_DMA);
  assign bus.O_dma_rdata  = bus.I_ram_rdata;
  assign bus.O_cpu_data_r = bus.I_ram_rdata;

endmodule

// File: tb/tb_c5_mem_arbiter.sv
// Directed bench for c5_mem_arbiter (STARVE_MAX 4 and 0).
// Table-driven cycles on instance a, hand sequence on instance b.
module tb_c5_mem_arbiter;
  import c5_pkg::*;

  localparam logic [31:0] CW = 32'hC0C0_C0C0;
  localparam logic [31:0] WD = 32'h0000_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c5_mem_arbiter_if a ();
  c5_mem_arbiter_if b ();

  c5_mem_arbiter #(.STARVE_MAX(4)) dut_a (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (a)
  );

  c5_mem_arbiter #(.STARVE_MAX(0)) dut_b (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (b)
  );

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (!a.I_ram_wait) begin
      for (int k = 0; k < 4; k++)
        if (a.O_ram_we[k])
          mem[a.O_ram_addr[9:0]][8*k +: 8] <= a.O_ram_wdata[8*k +: 8];
    end
    a.I_ram_rdata <= mem[a.O_ram_addr[9:0]];
  end

  always @(posedge clk)
    b.I_ram_rdata <= {2'b00, b.O_ram_addr} ^ 32'hA500_0000;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [29:0] ca;
    logic        req;
    logic [29:0] da;
    logic [3:0]  dwe;
    logic [31:0] dwd;
    logic        wt;
    logic [29:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic        e_pause;
    logic        e_ack;
    logic        e_rv;
    logic        c_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t v[$];

  // CPU owns the slot, DMA idle
  function automatic void idle(logic r, logic [29:0] ca, logic w,
                               logic rv, logic crd, logic [31:0] rd);
    v.push_back('{r, ca, 1'b0, 30'h0, 4'h0, 32'h0, w,
                  ca, 4'h0, CW, w, 1'b0, rv, crd, rd});
  endfunction

  // DMA pending but not yet due
  function automatic void pend(logic r, logic [29:0] ca, logic [29:0] da,
                               logic [3:0] dwe, logic [31:0] dwd,
                               logic crd, logic [31:0] rd);
    v.push_back('{r, ca, 1'b1, da, dwe, dwd, 1'b0,
                  ca, 4'h0, CW, 1'b0, 1'b0, 1'b0, crd, rd});
  endfunction

  // DMA owns the slot; w = RAM wait
  function automatic void own(logic [29:0] ca, logic [29:0] da,
                              logic [3:0] dwe, logic [31:0] dwd,
                              logic w);
    v.push_back('{1'b0, ca, 1'b1, da, dwe, dwd, w,
                  da, dwe, dwd, 1'b1, ~w, 1'b0, 1'b0, 32'h0});
  endfunction

  task automatic cyc_a(input int i, input vec_t x);
    @(negedge clk);
    rst                  = x.rst;
    a.I_cpu_address_next = x.ca;
    a.I_dma_req          = x.req;
    a.I_dma_addr         = x.da;
    a.I_dma_we           = x.dwe;
    a.I_dma_wdata        = x.dwd;
    a.I_ram_wait         = x.wt;
    #2;
    chk($sformatf("v%0d addr", i), 32'(a.O_ram_addr), 32'(x.e_addr));
    chk($sformatf("v%0d we", i), 32'(a.O_ram_we), 32'(x.e_we));
    chk($sformatf("v%0d wdata", i), a.O_ram_wdata, x.e_wd);
    chk($sformatf("v%0d pause", i), 32'(a.O_cpu_pause), 32'(x.e_pause));
    chk($sformatf("v%0d ack", i), 32'(a.O_dma_ack), 32'(x.e_ack));
    chk($sformatf("v%0d rvalid", i), 32'(a.O_dma_rvalid), 32'(x.e_rv));
    if (x.c_rd) begin
      chk($sformatf("v%0d cpu_rd", i), a.O_cpu_data_r, x.e_rd);
      chk($sformatf("v%0d dma_rd", i), a.O_dma_rdata, x.e_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[10'h100] = 32'hDEAD_BEEF;
    mem[10'h020] = 32'h1234_5678;

    a.I_cpu_address_next = '0;
    a.I_cpu_byte_we_next = 4'h0;
    a.I_cpu_data_w       = CW;
    a.I_dma_req          = 1'b0;
    a.I_dma_addr         = '0;
    a.I_dma_we           = 4'h0;
    a.I_dma_wdata        = '0;
    a.I_ram_wait         = 1'b0;
    b.I_cpu_address_next = 30'h77;
    b.I_cpu_byte_we_next = 4'h0;
    b.I_cpu_data_w       = CW;
    b.I_dma_req          = 1'b0;
    b.I_dma_addr         = '0;
    b.I_dma_we           = 4'h0;
    b.I_dma_wdata        = '0;
    b.I_ram_wait         = 1'b0;

    // reset: combinational paths live, wait forces pause
    idle(1'b1, 30'h55, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1, 30'h55, 1'b0, 1'b0, 1'b0, 32'h0);

    // CPU streaming, read data one cycle behind the address
    for (int i = 0; i < 8; i++)
      idle(1'b0, 30'(i), 1'b0, 1'b0, i > 0, 32'h1000_0000 + 32'(i) - 1);

    // DMA read 0x100: granted in cycle 4, data next cycle
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'h8, 30'h100, 4'h0, 32'h0, k == 0, 32'h1000_0007);
    own(30'h8, 30'h100, 4'h0, 32'h0, 1'b0);
    idle(1'b0, 30'h8, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);

    // DMA byte write 0x20, then CPU reads merged word
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'h9, 30'h20, 4'h3, WD, 1'b0, 32'h0);
    own(30'h9, 30'h20, 4'h3, WD, 1'b0);
    idle(1'b0, 30'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1'b0, 30'h20, 1'b0, 1'b0, 1'b1, 32'h1234_A5A5);

    // RAM wait across a due grant: ack deferred until wait drops
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'hA, 30'h101, 4'h0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++)
      own(30'hA, 30'h101, 4'h0, 32'h0, 1'b1);
    own(30'hA, 30'h101, 4'h0, 32'h0, 1'b0);
    idle(1'b0, 30'hA, 1'b0, 1'b1, 1'b1, 32'h1000_0101);

    // request withdrawn early restarts the count
    for (int k = 0; k < 2; k++)
      pend(1'b0, 30'hB, 30'h102, 4'h0, 32'h0, 1'b0, 32'h0);
    idle(1'b0, 30'hB, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'hB, 30'h102, 4'h0, 32'h0, 1'b0, 32'h0);
    own(30'hB, 30'h102, 4'h0, 32'h0, 1'b0);
    idle(1'b0, 30'hB, 1'b0, 1'b1, 1'b1, 32'h1000_0102);

    // reset the cycle after a read ack drops the pending rvalid
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'hC, 30'h100, 4'h0, 32'h0, 1'b0, 32'h0);
    own(30'hC, 30'h100, 4'h0, 32'h0, 1'b0);
    pend(1'b1, 30'hC, 30'h100, 4'h0, 32'h0, 1'b0, 32'h0);
    idle(1'b0, 30'hC, 1'b0, 1'b0, 1'b0, 32'h0);

    // reset mid-count: full STARVE_MAX wait again after release
    for (int k = 0; k < 3; k++)
      pend(1'b0, 30'hD, 30'h103, 4'h0, 32'h0, 1'b0, 32'h0);
    pend(1'b1, 30'hD, 30'h103, 4'h0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      pend(1'b0, 30'hD, 30'h103, 4'h0, 32'h0, 1'b0, 32'h0);
    own(30'hD, 30'h103, 4'h0, 32'h0, 1'b0);
    idle(1'b0, 30'hD, 1'b0, 1'b1, 1'b1, 32'h1000_0103);

    foreach (v[i]) cyc_a(i, v[i]);

    // STARVE_MAX = 0: four back-to-back DMA reads
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b.I_dma_req  = (k < 4);
      b.I_dma_addr = 30'h40 + 30'(k);
      #2;
      chk($sformatf("b%0d ack", k), 32'(b.O_dma_ack), 32'(k < 4));
      chk($sformatf("b%0d pause", k), 32'(b.O_cpu_pause), 32'(k < 4));
      chk($sformatf("b%0d addr", k), 32'(b.O_ram_addr),
          (k < 4) ? 32'h40 + 32'(k) : 32'h77);
      chk($sformatf("b%0d rvalid", k), 32'(b.O_dma_rvalid), 32'(k > 0));
      if (k > 0)
        chk($sformatf("b%0d rdata", k), b.O_dma_rdata,
            (32'h40 + 32'(k) - 1) ^ 32'hA500_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/c5_mem_arbiter.md
# c5_mem_arbiter

Two-master arbiter that shares the single-port synchronous SoC RAM between the c5_cpu memory port and a secondary DMA/loader master. The CPU has default ownership. The DMA master is served through a req/ack handshake with a bounded wait (anti-starvation counter). The CPU is held off with its existing pause input whenever it loses a slot or the RAM signals wait. The block sits between c5_cpu, the DMA master and the RAM inside soc.

## Interface
Parameters:
- STARVE_MAX, 4: cycles a pending DMA request may be denied before it is forced through; 0 gives DMA strict priority; range 0..15.

Ports (clock and reset first):
- I_clk  in  1  system clock (CC_PLL CLK0)
- I_rst  in  1  asynchronous, active-high reset
- I_cpu_address_next  in  30  CPU word address [31:2] for the next RAM slot
- I_cpu_byte_we_next  in  4  CPU byte write enables for the next slot
- I_cpu_data_w  in  32  CPU write data
- O_cpu_data_r  out  32  read data to CPU
- O_cpu_pause  out  1  to c5_cpu I_mem_pause; CPU holds its request while high
- I_dma_req  in  1  DMA request, held until ack
- I_dma_addr  in  30  DMA word address
- I_dma_we  in  4  DMA byte write enables (0 = read)
- I_dma_wdata  in  32  DMA write data
- O_dma_ack  out  1  one-cycle grant; slot issued this cycle
- O_dma_rvalid  out  1  DMA read data valid
- O_dma_rdata  out  32  DMA read data
- O_ram_addr  out  30  RAM word address
- O_ram_we  out  4  RAM byte write enables
- O_ram_wdata  out  32  RAM write data
- I_ram_rdata  in  32  RAM read data; valid the cycle after the address edge
- I_ram_wait  in  1  RAM/peripheral not ready; the current slot is not accepted

## Operation
- Owner per cycle (combinational), either OWN_CPU or OWN_DMA:
  - OWN_DMA when I_dma_req and (wait_cnt >= STARVE_MAX or STARVE_MAX == 0); otherwise OWN_CPU.
- RAM mux: O_ram_addr, O_ram_we and O_ram_wdata come from the owner's inputs.
- O_cpu_pause = (owner == OWN_DMA) | I_ram_wait.
- O_dma_ack = (owner == OWN_DMA) & ~I_ram_wait.
- wait_cnt (4-bit register):
  - Clears when O_dma_ack = 1 or I_dma_req = 0.
  - Increments, saturating at 15, when I_dma_req = 1, O_dma_ack = 0 and I_ram_wait = 0.
  - Holds when I_ram_wait = 1.
- rd_owner register: set to the accepted owner each non-wait cycle. While I_ram_wait = 1 the issued slot is not accepted and rd_owner holds.
- rd_dma_read register: set to 1 when an accepted DMA slot has O_ram_we == 0.
- O_dma_rvalid = rd_dma_read, registered one cycle after the ack.
- O_dma_rdata = I_ram_rdata.
- O_cpu_data_r = I_ram_rdata; the CPU ignores it while paused.
- DMA writes produce no rvalid.
- Back-to-back DMA: if I_dma_req stays high after an ack, wait_cnt restarts from 0, so DMA receives at most 1 slot per STARVE_MAX+1 cycles (STARVE_MAX > 0).

## Timing
- Reset values: wait_cnt = 0, rd_owner = OWN_CPU, rd_dma_read = 0, O_dma_rvalid = 0.
- Combinational outputs follow their inputs during reset: O_cpu_pause = I_ram_wait, O_ram_* = CPU inputs.
- DMA read latency: ack at cycle t, O_dma_rvalid and data at cycle t+1.
- Worst-case DMA grant latency with I_ram_wait = 0: STARVE_MAX cycles after req rises (granted in cycle index STARVE_MAX, counting from 0).
- Simultaneous DMA grant and I_ram_wait: no ack, CPU paused, wait_cnt held. The grant repeats next cycle.
- I_dma_req dropped before ack: legal. wait_cnt clears and no slot is issued.
- Reset asserted mid-transfer: a pending rvalid is discarded and the counter clears. The DMA master must reissue.
- All registers update on the rising edge of I_clk. There are no combinational paths from I_ram_rdata to control signals.

## Structure
- Package c5_pkg holds:
  - owner enum OWN_CPU/OWN_DMA
  - C5_WADDR_W = 30
  - C5_STARVE_DEF = 4
- One sub-module, c5_arb_wait_cnt: the saturating wait counter with clear/hold/inc inputs and a `due` output (cnt >= STARVE_MAX).
- The owner mux and the read-return pipeline stay in c5_mem_arbiter.

## Test plan
- DMA idle, CPU streams addresses 0x0..0x7 -> O_ram_addr follows CPU each cycle; O_cpu_pause = 0 throughout.
- STARVE_MAX = 4, DMA read req at cycle 0, addr 0x100, RAM[0x100] = 0xDEADBEEF -> ack at cycle 4, CPU paused at cycle 4 only, O_dma_rvalid with 0xDEADBEEF at cycle 5.
- DMA write addr 0x20, we = 4'b0011, wdata 0x0000A5A5 -> a single ack, RAM bytes 0-1 written, no rvalid; CPU read of 0x20 afterwards returns the merged value.
- I_ram_wait high for 3 cycles across a due DMA grant -> no ack and O_cpu_pause = 1 during wait; ack in the first cycle after wait drops.
- STARVE_MAX = 0, DMA req held for 4 cycles -> 4 consecutive acks, CPU paused 4 cycles, rvalid follows each read.
- Assert I_rst in the cycle after a DMA read ack -> O_dma_rvalid = 0 immediately, wait_cnt = 0, owner returns to CPU on release.
